// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared definitions for the front end: datapath width, reset
//            fetch address, major opcode constants and the fetch state type.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
    localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;

    // RUN: every response is kept. DRAIN: responses to requests issued
    // before the last redirect are still in flight and must be discarded.
    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO with flush and occupancy count. The head
//            entry is read straight from storage (no output register), so a
//            word pushed at edge N is visible at the head after that edge.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            flush          - empties the FIFO (dominates push/pop)
//            push/push_data - write one entry
//            pop            - remove head entry (caller guarantees non-empty)
//            head_data      - current head entry
//            count          - number of entries held (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two. Push and pop
    // in the same cycle when full is safe: the old head is read before the
    // edge that overwrites its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the PC, issues in-order word
//            requests to instruction memory, buffers returned words in a
//            prefetch FIFO and hands them to decode with valid/ready.
//            A redirect pulse reloads the PC, flushes buffered words and
//            marks every in-flight request as stale.
// Config   : FETCH_ILLEGAL_CHECK_EN - when defined, inst_illegal flags a
//            valid head whose low two bits are not 2'b11; otherwise tied 0.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            imem_req/addr/gnt/rvalid/rdata  - instruction memory interface
//            redirect_valid/redirect_pc      - branch/jump redirect
//            inst_valid/ready/data/pc        - decode handshake
//            opcode                          - inst_data[6:0] to decoder
//            inst_illegal                    - non-32-bit encoding at head
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int          XLEN       = riscv_pkg::XLEN,
    parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic            inst_illegal
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   drop;
    fetch_state_t    state;

    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [XLEN-1:0] resp_pc;
    logic            grant;
    logic            keep;
    logic            pop;

    // Capacity is reserved at grant time, so buffered plus in-flight words
    // can never exceed the FIFO depth.
    assign imem_req  = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH);
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    // A response is kept only outside DRAIN and outside a redirect cycle.
    assign keep = imem_rvalid && (state == FETCH_RUN) && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    // Requests in flight after this cycle's grant/response; on redirect all
    // of them become stale.
    assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);

    // Address queue: one entry per in-flight request, so its occupancy is
    // the outstanding-request count. Never flushed, because stale responses
    // still arrive and must retire their entries.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_addr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (grant),
        .push_data (pc),
        .pop       (imem_rvalid),
        .head_data (resp_pc),
        .count     (outstanding)
    );

    // Prefetch FIFO: {pc, instruction} per entry.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_inst_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (keep),
        .push_data ({resp_pc, imem_rdata}),
        .pop       (pop),
        .head_data ({inst_pc, inst_data}),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC[XLEN-1:0] & ~XLEN'(3);
            drop  <= '0;
            state <= FETCH_RUN;
        end else if (redirect_valid) begin
            pc    <= redirect_pc & ~XLEN'(3);
            drop  <= outstanding_next;
            state <= (outstanding_next != '0) ? FETCH_DRAIN : FETCH_RUN;
        end else begin
            if (grant) begin
                pc <= pc + XLEN'(4);
            end
            if (imem_rvalid && (state == FETCH_DRAIN)) begin
                drop <= drop - CW'(1);
                if (drop == CW'(1)) begin
                    state <= FETCH_RUN;
                end
            end
        end
    end

    assign inst_valid = (count != '0);
    assign opcode     = inst_data[6:0];

`ifdef FETCH_ILLEGAL_CHECK_EN
    assign inst_illegal = inst_valid && (inst_data[1:0] != 2'b11);
`else
    assign inst_illegal = 1'b0;
`endif

endmodule : fetch_unit
`default_nettype wire
